// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-write/single-read register memory.
// Mixed read/write pairs share the ports in one cycle; same-type pairs alternate via prio.
module mem_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rstn,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  logic prio;       // 0: requester 0 wins a same-type tie
  logic rown_vld;   // a read was granted last cycle
  logic rown;       // owner of that read
  logic same_type;

  assign same_type = req0 & req1 & (rw0 == rw1);

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (!rst) begin
      gnt0 = req0 & (~same_type | ~prio);
      gnt1 = req1 & (~same_type |  prio);
      if (gnt0 & rw0) begin
        mem_we    = 1'b1;
        mem_waddr = addr0;
        mem_wdata = wdata0;
      end else if (gnt1 & rw1) begin
        mem_we    = 1'b1;
        mem_waddr = addr1;
        mem_wdata = wdata1;
      end
      if (gnt0 & ~rw0) begin
        mem_re    = 1'b1;
        mem_raddr = addr0;
      end else if (gnt1 & ~rw1) begin
        mem_re    = 1'b1;
        mem_raddr = addr1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio           <= 1'b0;
      rown_vld       <= 1'b0;
      rown           <= 1'b0;
      contention_cnt <= '0;
    end else begin
      rown_vld <= mem_re;
      rown     <= gnt1 & ~rw1;
      if (same_type) begin
        prio <= ~prio;
        if (contention_cnt != '1) contention_cnt <= contention_cnt + CNT_W'(1);
      end
    end
  end

  // Memory read is registered, so rdata is simply forwarded and qualified by rvalid.
  assign rvalid0  = rown_vld & ~rown;
  assign rvalid1  = rown_vld &  rown;
  assign rdata    = mem_rdata;
  assign mem_rstn = ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; includes a 16x8 registered-read memory.
module tb_mem_port_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_rstn, mem_we, mem_re;
  logic [7:0] rdata, mem_wdata, mem_rdata, contention_cnt;
  logic [3:0] mem_waddr, mem_raddr;
  logic       mem_clear = 1'b0;
  logic [7:0] mem_arr [16];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_rstn(mem_rstn), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .contention_cnt(contention_cnt));

  // memory: read-before-write, registered read with active-low async reset
  always @(posedge clk) begin
    if (mem_clear) for (int i = 0; i < 16; i++) mem_arr[i] <= 8'h00;
    else if (mem_we) mem_arr[mem_waddr] <= mem_wdata;
  end
  always @(posedge clk or negedge mem_rstn) begin
    if (!mem_rstn) mem_rdata <= 8'h00;
    else if (mem_re) mem_rdata <= mem_arr[mem_raddr];
  end

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    req0 = 0; req1 = 0; rst = 1;
    next_cyc(); next_cyc();
    rst = 0;
  endtask

  task automatic test_reset;
    req0 = 1; rw0 = 1; addr0 = 4'd7; req1 = 1; rw1 = 0; rst = 1;
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, mem_we, mem_re, rvalid0, rvalid1, mem_rstn} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=0000000",
        {gnt0, gnt1, mem_we, mem_re, rvalid0, rvalid1, mem_rstn});
    end
    n_cmp++;
    if (contention_cnt !== 8'h00) begin
      n_err++; $display("FAIL reset_cnt got=%h exp=00", contention_cnt);
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (mem_rstn !== 1'b1) begin n_err++; $display("FAIL reset_release_rstn got=%b exp=1", mem_rstn); end
  endtask

  task automatic test_single;
    apply_reset();
    req0 = 1; rw0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, mem_we, mem_re, mem_waddr, mem_wdata} !== {4'b1010, 4'd3, 8'hA5}) begin
      n_err++; $display("FAIL single_write got=%b/%h/%h exp=1010/3/a5",
        {gnt0, gnt1, mem_we, mem_re}, mem_waddr, mem_wdata);
    end
    next_cyc(); rw0 = 0;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, mem_we, mem_re, mem_raddr, rvalid0} !== {4'b1001, 4'd3, 1'b0}) begin
      n_err++; $display("FAIL single_read got=%b/%h/%b exp=1001/3/0",
        {gnt0, gnt1, mem_we, mem_re}, mem_raddr, rvalid0);
    end
    next_cyc(); req0 = 0;
    @(negedge clk);
    n_cmp++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'hA5}) begin
      n_err++; $display("FAIL single_return got=%b/%h exp=10/a5", {rvalid0, rvalid1}, rdata);
    end
  endtask

  task automatic test_contention_read;
    req0 = 1; rw0 = 1; addr0 = 4'd1; wdata0 = 8'h21; next_cyc();
    addr0 = 4'd2; wdata0 = 8'h42; next_cyc();
    apply_reset();
    req0 = 1; rw0 = 0; addr0 = 4'd1; req1 = 1; rw1 = 0; addr1 = 4'd2;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, mem_raddr} !== {2'b10, 4'd1}) begin
      n_err++; $display("FAIL contend_c1 got=%b/%h exp=10/1", {gnt0, gnt1}, mem_raddr);
    end
    next_cyc(); req0 = 0;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, mem_raddr, rvalid0, rvalid1, rdata} !== {2'b01, 4'd2, 2'b10, 8'h21}) begin
      n_err++; $display("FAIL contend_c2 got=%b/%h/%b/%h exp=01/2/10/21",
        {gnt0, gnt1}, mem_raddr, {rvalid0, rvalid1}, rdata);
    end
    next_cyc(); req1 = 0;
    @(negedge clk);
    n_cmp++;
    if ({rvalid0, rvalid1, rdata, contention_cnt} !== {2'b01, 8'h42, 8'd1}) begin
      n_err++; $display("FAIL contend_c3 got=%b/%h/%0d exp=01/42/1",
        {rvalid0, rvalid1}, rdata, contention_cnt);
    end
  endtask

  task automatic test_mixed;
    req0 = 1; rw0 = 1; addr0 = 4'd5; wdata0 = 8'h11; req1 = 0;
    next_cyc();
    wdata0 = 8'h3C; req1 = 1; rw1 = 0; addr1 = 4'd5;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, mem_we, mem_re, mem_waddr, mem_raddr} !== {4'b1111, 4'd5, 4'd5}) begin
      n_err++; $display("FAIL mixed_grant got=%b/%h/%h exp=1111/5/5",
        {gnt0, gnt1, mem_we, mem_re}, mem_waddr, mem_raddr);
    end
    next_cyc(); req0 = 0;
    @(negedge clk);
    n_cmp++;
    if ({gnt1, rvalid0, rvalid1, rdata} !== {3'b101, 8'h11}) begin
      n_err++; $display("FAIL mixed_old_data got=%b/%h exp=101/11", {gnt1, rvalid0, rvalid1}, rdata);
    end
    next_cyc(); req1 = 0;
    @(negedge clk);
    n_cmp++;
    if ({rvalid1, rdata} !== {1'b1, 8'h3C}) begin
      n_err++; $display("FAIL mixed_new_data got=%b/%h exp=1/3c", rvalid1, rdata);
    end
  endtask

  task automatic test_fairness;
    logic exp0;
    apply_reset();
    req0 = 1; rw0 = 1; addr0 = 4'd8; req1 = 1; rw1 = 1; addr1 = 4'd9;
    exp0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata0 = 8'(i); wdata1 = 8'(i + 8'h80);
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1} !== {exp0, !exp0}) begin
        n_err++; $display("FAIL fair_cycle%0d got=%b exp=%b", i, {gnt0, gnt1}, {exp0, !exp0});
      end
      exp0 = !exp0;
      next_cyc();
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    n_cmp++;
    if (contention_cnt !== 8'd6) begin
      n_err++; $display("FAIL fair_cnt got=%0d exp=6", contention_cnt);
    end
  endtask

  task automatic test_saturation;
    apply_reset();
    req0 = 1; rw0 = 0; addr0 = 4'd0; req1 = 1; rw1 = 0; addr1 = 4'd1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 254) begin
        n_cmp++;
        if (contention_cnt !== 8'd254) begin
          n_err++; $display("FAIL sat_pre got=%0d exp=254", contention_cnt);
        end
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    n_cmp++;
    if (contention_cnt !== 8'hFF) begin
      n_err++; $display("FAIL sat_cnt got=%h exp=ff", contention_cnt);
    end
  endtask

  task automatic test_reset_mid_read;
    apply_reset();
    // leave prio = 1 so the post-reset tie shows the pointer was cleared
    req0 = 1; rw0 = 1; req1 = 1; rw1 = 1; next_cyc();
    req0 = 0; req1 = 1; rw1 = 0; addr1 = 4'd4;
    @(negedge clk);
    n_cmp++;
    if (gnt1 !== 1'b1) begin n_err++; $display("FAIL rmid_grant got=%b exp=1", gnt1); end
    rst = 1; #1;
    n_cmp++;
    if ({rvalid1, mem_rstn, gnt1, mem_re} !== 4'b0) begin
      n_err++; $display("FAIL rmid_during got=%b exp=0000", {rvalid1, mem_rstn, gnt1, mem_re});
    end
    next_cyc();
    rst = 0; req1 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
        n_err++; $display("FAIL rmid_after%0d got=%b exp=00", i, {rvalid0, rvalid1});
      end
      next_cyc();
    end
    req0 = 1; rw0 = 0; req1 = 1; rw1 = 0;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++; $display("FAIL rmid_tie got=%b exp=10", {gnt0, gnt1});
    end
    next_cyc(); req0 = 0; req1 = 0;
  endtask

  // Reference: pending-request queues per requester, a flat memory image and
  // a fair tie-breaker token, evaluated once per cycle at transaction level.
  task automatic test_random;
    logic p0 = 0, p1 = 0, w0 = 0, w1 = 0, e0, e1, tie;
    logic [3:0] a0 = 0, a1 = 0;
    logic [7:0] d0 = 0, d1 = 0;
    int   turn = 0, m_cnt = 0, rv_owner = -1;
    logic [7:0] m_rexp = 0;
    logic [7:0] m_mem [16];
    logic [7:0] exp_wa, exp_ra;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    mem_clear = 1; next_cyc(); mem_clear = 0;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && $urandom_range(9) < 6) begin
        p0 = 1; w0 = 1'($urandom_range(1)); a0 = 4'($urandom_range(3)); d0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(9) < 6) begin
        p1 = 1; w1 = 1'($urandom_range(1)); a1 = 4'($urandom_range(3)); d1 = 8'($urandom);
      end
      req0 = p0; rw0 = w0; addr0 = a0; wdata0 = d0;
      req1 = p1; rw1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
      tie = p0 && p1 && (w0 == w1);
      e0 = tie ? (turn == 0) : p0;
      e1 = tie ? (turn == 1) : p1;
      n_cmp++;
      if ({gnt0, gnt1} !== {e0, e1}) begin
        n_err++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {gnt0, gnt1}, {e0, e1});
      end
      exp_wa = (e0 && w0) ? {4'd0, a0} : {4'd0, a1};
      exp_ra = (e0 && !w0) ? {4'd0, a0} : {4'd0, a1};
      n_cmp++;
      if ({mem_we, mem_re} !== {(e0 && w0) || (e1 && w1), (e0 && !w0) || (e1 && !w1)}) begin
        n_err++; $display("FAIL rnd_ports c=%0d got=%b", c, {mem_we, mem_re});
      end else begin
        if (mem_we) begin
          n_cmp++;
          if ({mem_waddr, mem_wdata} !== {exp_wa[3:0], (e0 && w0) ? d0 : d1}) begin
            n_err++; $display("FAIL rnd_wport c=%0d got=%h/%h", c, mem_waddr, mem_wdata);
          end
        end
        if (mem_re) begin
          n_cmp++;
          if (mem_raddr !== exp_ra[3:0]) begin
            n_err++; $display("FAIL rnd_raddr c=%0d got=%h exp=%h", c, mem_raddr, exp_ra[3:0]);
          end
        end
      end
      n_cmp++;
      if ({rvalid0, rvalid1} !== {rv_owner == 0, rv_owner == 1}) begin
        n_err++; $display("FAIL rnd_rvalid c=%0d got=%b owner=%0d", c, {rvalid0, rvalid1}, rv_owner);
      end else if (rv_owner >= 0) begin
        n_cmp++;
        if (rdata !== m_rexp) begin
          n_err++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, m_rexp);
        end
      end
      n_cmp++;
      if (contention_cnt !== 8'(m_cnt)) begin
        n_err++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, contention_cnt, m_cnt);
      end
      rv_owner = -1;
      if (e0 && !w0) begin rv_owner = 0; m_rexp = m_mem[a0]; end
      if (e1 && !w1) begin rv_owner = 1; m_rexp = m_mem[a1]; end
      if (e0 && w0) m_mem[a0] = d0;
      if (e1 && w1) m_mem[a1] = d1;
      if (tie) begin turn = 1 - turn; if (m_cnt < 255) m_cnt++; end
      if (e0) p0 = 0;
      if (e1) p1 = 0;
      next_cyc();
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention_read();
    test_mixed();
    test_fairness();
    test_saturation();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
